fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 131 +++++++++++++
 tb/tb_fetch_prefetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetch queue in front of an in-order memory.
// Requests are allocated into a DEPTH-entry circular queue at accept and
// filled in order as responses return. Redirects flush the queue and count
// the in-flight responses that must be dropped.
// Optional feature macro: FETCH_PREFETCH_FLUSHCNT_EN (redirect counter on FlushCntF).
module fetch_prefetch #(
    parameter int             N        = 32,
    parameter int             DEPTH    = 4,
    parameter int             PC_STEP  = 4,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ResultW,
    input  logic         PCSrcW,
    input  logic [N-1:0] ExtImmE,
    input  logic         BranchTakenE,
    input  logic         StallF,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    output logic [N-1:0] InstrF,
    output logic [N-1:0] PCF,
    output logic [N-1:0] PCPlus4F,
    output logic         ValidF,
    output logic [15:0]  FlushCntF
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8;

    typedef enum logic [1:0] {BOOT, RUN, FULL} state_t;

    state_t        state;
    logic [N-1:0]  fpc;
    logic [N-1:0]  q_pc    [DEPTH];
    logic [N-1:0]  q_instr [DEPTH];
    // head: oldest entry, fptr: oldest unfilled entry, tail: next allocation.
    // An entry is filled exactly when it lies in [head, fptr).
    logic [AW:0]   head, fptr, tail;
    logic [DW-1:0] discard;

    logic          redirect;
    logic [N-1:0]  target;
    logic [AW:0]   count, unfilled, count_nx;
    logic [DW-1:0] outstanding;
    logic          acc, deq, fill, drop;

    // Redirect selection, queue occupancy and per-cycle handshake decisions
    always_comb begin
        redirect    = BranchTakenE | PCSrcW;
        target      = BranchTakenE ? ExtImmE : ResultW;
        count       = tail - head;
        unfilled    = tail - fptr;
        outstanding = discard + DW'(unfilled);
        ValidF      = (fptr != head) && !redirect;
        deq         = ValidF && !StallF;
        // In FULL a request may go out only when the head leaves this cycle
        imem_req_valid = !redirect && ((state == RUN) || ((state == FULL) && deq));
        acc         = imem_req_valid && imem_req_ready;
        drop        = imem_rsp_valid && (discard != '0);
        fill        = imem_rsp_valid && (discard == '0) && (unfilled != '0);
        count_nx    = count + (AW+1)'(acc) - (AW+1)'(deq);
    end

    assign imem_addr = fpc;
    assign InstrF    = q_instr[head[AW-1:0]];
    assign PCF       = q_pc[head[AW-1:0]];
    assign PCPlus4F  = PCF + N'(PC_STEP);

    // FSM, fetch PC, queue pointers/entries and response discard bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            fpc     <= RESET_PC;
            head    <= '0;
            fptr    <= '0;
            tail    <= '0;
            discard <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= RESET_PC;
                q_instr[i] <= '0;
            end
        end else if (redirect) begin
            fpc   <= target;
            head  <= '0;
            fptr  <= '0;
            tail  <= '0;
            state <= RUN;
            // Every request still in flight comes back later and must be
            // dropped, except one whose response lands this very cycle.
            discard <= outstanding - DW'(imem_rsp_valid && (outstanding != '0));
        end else begin
            if (acc) begin
                q_pc[tail[AW-1:0]] <= fpc;
                fpc  <= fpc + N'(PC_STEP);
                tail <= tail + 1'b1;
            end
            if (deq)
                head <= head + 1'b1;
            if (fill) begin
                q_instr[fptr[AW-1:0]] <= imem_rsp_data;
                fptr <= fptr + 1'b1;
            end
            if (drop)
                discard <= discard - 1'b1;
            if (state == BOOT)
                state <= RUN;
            else
                state <= (count_nx == (AW+1)'(DEPTH)) ? FULL : RUN;
        end
    end

`ifdef FETCH_PREFETCH_FLUSHCNT_EN
    logic [15:0] flushcnt;

    // Saturating count of redirect cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flushcnt <= '0;
        else if (redirect && (flushcnt != 16'hFFFF))
            flushcnt <= flushcnt + 16'd1;
    end

    assign FlushCntF = flushcnt;
`else
    assign FlushCntF = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: in-order memory model with adjustable
// latency and a hold switch, one task per scenario, inline comparisons.
module tb_fetch_prefetch;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_PREFETCH_FLUSHCNT_EN
    localparam logic [15:0] EXP_FLUSH = 16'd3;
`else
    localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ResultW = '0, ExtImmE = '0;
    logic        PCSrcW = 1'b0, BranchTakenE = 1'b0, StallF = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        ValidF;
    logic [15:0] FlushCntF;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    bit mem_hold = 1'b0;
    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] acc_log[$];

    fetch_prefetch dut (
        .clk(clk), .rst(rst), .ResultW(ResultW), .PCSrcW(PCSrcW),
        .ExtImmE(ExtImmE), .BranchTakenE(BranchTakenE), .StallF(StallF),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FlushCntF(FlushCntF)
    );

    always #5 clk = ~clk;

    // In-order memory: responds lat cycles after accept, stalls while mem_hold
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst) begin
                pend_a.delete();
                pend_d.delete();
                imem_rsp_valid <= 1'b0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    pend_a.push_back(imem_addr);
                    pend_d.push_back(cyc + lat - 1);
                    acc_log.push_back(imem_addr);
                end
                if (pend_a.size() > 0 && pend_d[0] <= cyc && !mem_hold) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= pend_a[0] ^ MAGIC;
                    void'(pend_a.pop_front());
                    void'(pend_d.pop_front());
                end else begin
                    imem_rsp_valid <= 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        ResultW = '0; ExtImmE = '0; PCSrcW = 1'b0; BranchTakenE = 1'b0;
        StallF = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        acc_log.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        total++; if (ValidF !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ValidF); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_reqv got=%b exp=0", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        total++; if (PCF !== 32'h0) begin bad++; $display("FAIL reset_pcf got=%h exp=0", PCF); end
        total++; if (PCPlus4F !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", PCPlus4F); end
        total++; if (InstrF !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", InstrF); end
        total++; if (FlushCntF !== 16'h0) begin bad++; $display("FAIL reset_flush got=%h exp=0", FlushCntF); end
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stream_reqv got=%b exp=1", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stream_addr0 got=%h exp=0", imem_addr); end
        total++; if (ValidF !== 1'b0) begin bad++; $display("FAIL stream_v1 got=%b exp=0", ValidF); end
        @(negedge clk);
        total++; if (ValidF !== 1'b0) begin bad++; $display("FAIL stream_v2 got=%b exp=0", ValidF); end
        @(negedge clk);
        total++; if (ValidF !== 1'b1) begin bad++; $display("FAIL stream_v3 got=%b exp=1", ValidF); end
        total++; if (PCF !== 32'h0) begin bad++; $display("FAIL stream_pc0 got=%h exp=0", PCF); end
        total++; if (InstrF !== MAGIC) begin bad++; $display("FAIL stream_i0 got=%h exp=%h", InstrF, MAGIC); end
        total++; if (PCPlus4F !== 32'h4) begin bad++; $display("FAIL stream_pc4 got=%h exp=4", PCPlus4F); end
        @(negedge clk);
        total++; if (PCF !== 32'h4 || ValidF !== 1'b1) begin bad++; $display("FAIL stream_pc1 got=%h/%b exp=4/1", PCF, ValidF); end
        @(negedge clk);
        total++; if (PCF !== 32'h8) begin bad++; $display("FAIL stream_pc2 got=%h exp=8", PCF); end
        total++; if (InstrF !== (32'h8 ^ MAGIC)) begin bad++; $display("FAIL stream_i2 got=%h exp=%h", InstrF, 32'h8 ^ MAGIC); end
        total++;
        if (acc_log.size() < 4) begin
            bad++; $display("FAIL stream_reqcnt got=%0d exp>=4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_reqaddr%0d got=%h exp=%h", i, acc_log[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        StallF = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (acc_log.size() != 4) begin bad++; $display("FAIL stall_reqcnt got=%0d exp=4", acc_log.size()); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_reqv got=%b exp=0", imem_req_valid); end
        total++; if (ValidF !== 1'b1 || PCF !== 32'h0) begin bad++; $display("FAIL stall_head got=%b/%h exp=1/0", ValidF, PCF); end
        total++; if (dut.state !== 2'd2) begin bad++; $display("FAIL stall_full got=%0d exp=2", dut.state); end
        // Releasing the stall while full lets a request go out alongside the dequeue
        StallF = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL full_swap_req got=%b/%h exp=1/10", imem_req_valid, imem_addr); end
        @(negedge clk);
        total++; if (PCF !== 32'h4) begin bad++; $display("FAIL full_swap_pc got=%h exp=4", PCF); end
        total++; if (acc_log.size() != 5) begin bad++; $display("FAIL full_swap_cnt got=%0d exp=5", acc_log.size()); end
        total++; if (dut.state !== 2'd2) begin bad++; $display("FAIL full_swap_state got=%0d exp=2", dut.state); end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_hold = 1'b1;
        repeat (3) @(negedge clk);
        // Two requests (0, 4) outstanding with their responses held back
        imem_req_ready = 1'b0;
        BranchTakenE = 1'b1; ExtImmE = 32'h100;
        #1;
        total++; if (ValidF !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_same got=%b/%b exp=0/0", ValidF, imem_req_valid); end
        @(negedge clk);
        BranchTakenE = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h100 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL redir_addr got=%h/%b exp=100/1", imem_addr, imem_req_valid); end
        for (int i = 0; i < 20 && ValidF !== 1'b1; i++) @(negedge clk);
        total++;
        if (ValidF !== 1'b1) begin
            bad++; $display("FAIL redir_timeout got=%b exp=1", ValidF);
        end else if (PCF !== 32'h100 || PCPlus4F !== 32'h104 || InstrF !== (32'h100 ^ MAGIC)) begin
            bad++; $display("FAIL redir_head got=%h/%h/%h exp=100/104/%h", PCF, PCPlus4F, InstrF, 32'h100 ^ MAGIC);
        end
    endtask

    task automatic test_both();
        do_reset();
        repeat (4) @(negedge clk);
        BranchTakenE = 1'b1; ExtImmE = 32'h200;
        PCSrcW = 1'b1; ResultW = 32'h300;
        #1;
        total++; if (ValidF !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL both_same got=%b/%b exp=0/0", ValidF, imem_req_valid); end
        @(negedge clk);
        BranchTakenE = 1'b0; PCSrcW = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL both_addr got=%h exp=200", imem_addr); end
        for (int i = 0; i < 20 && ValidF !== 1'b1; i++) @(negedge clk);
        total++;
        if (ValidF !== 1'b1 || PCF !== 32'h200 || InstrF !== (32'h200 ^ MAGIC)) begin
            bad++; $display("FAIL both_head got=%b/%h/%h exp=1/200/%h", ValidF, PCF, InstrF, 32'h200 ^ MAGIC);
        end
    endtask

    task automatic test_ready_low();
        int n0;
        do_reset();
        repeat (4) @(negedge clk);
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL rdy_start got=%h exp=c", imem_addr); end
        imem_req_ready = 1'b0;
        n0 = acc_log.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (imem_addr !== 32'hC || imem_req_valid !== 1'b1) begin bad++; $display("FAIL rdy_hold%0d got=%h/%b exp=c/1", i, imem_addr, imem_req_valid); end
        end
        total++; if (acc_log.size() != n0) begin bad++; $display("FAIL rdy_noalloc got=%0d exp=%0d", acc_log.size(), n0); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        total++;
        if (acc_log.size() != n0 + 1) begin
            bad++; $display("FAIL rdy_resume got=%0d exp=%0d", acc_log.size(), n0 + 1);
        end else if (acc_log[n0] !== 32'hC) begin
            bad++; $display("FAIL rdy_resume_addr got=%h exp=c", acc_log[n0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        BranchTakenE = 1'b1; ExtImmE = 32'hFFFF_FFFC;
        @(negedge clk);
        BranchTakenE = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", imem_addr); end
        @(negedge clk);
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", imem_addr); end
        for (int i = 0; i < 20 && ValidF !== 1'b1; i++) @(negedge clk);
        total++;
        if (ValidF !== 1'b1 || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
            bad++; $display("FAIL wrap_head got=%b/%h/%h exp=1/fffffffc/0", ValidF, PCF, PCPlus4F);
        end
    endtask

    task automatic test_flushcnt();
        do_reset();
        repeat (3) @(negedge clk);
        BranchTakenE = 1'b1; ExtImmE = 32'h40;
        @(negedge clk);
        BranchTakenE = 1'b0;
        repeat (2) @(negedge clk);
        PCSrcW = 1'b1; ResultW = 32'h500;
        @(negedge clk);
        PCSrcW = 1'b0;
        total++; if (imem_addr !== 32'h500) begin bad++; $display("FAIL pcsrc_addr got=%h exp=500", imem_addr); end
        @(negedge clk);
        BranchTakenE = 1'b1; ExtImmE = 32'h80;
        @(negedge clk);
        BranchTakenE = 1'b0;
        @(negedge clk);
        total++; if (FlushCntF !== EXP_FLUSH) begin bad++; $display("FAIL flushcnt got=%0d exp=%0d", FlushCntF, EXP_FLUSH); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_both();
        test_ready_low();
        test_wrap();
        test_flushcnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
